// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle controller:
// states, instruction classes, opcode patterns, control encodings.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_ERROR
   } state_e;

   typedef enum logic [3:0] {
      C_R, C_ADDI, C_LDUR, C_STUR, C_CBZ, C_CBNZ, C_B, C_HALT, C_ILL
   } cls_e;

   localparam logic [10:0] OP_LDUR = 11'b11111000010;
   localparam logic [10:0] OP_STUR = 11'b11111000000;
   localparam logic [10:0] OP_ADD  = 11'b10001011000;
   localparam logic [10:0] OP_SUB  = 11'b11001011000;
   localparam logic [10:0] OP_AND  = 11'b10001010000;
   localparam logic [10:0] OP_ORR  = 11'b10101010000;
   localparam logic [10:0] OP_ADDI = 11'b10010001000;
   localparam logic [10:0] OP_CBZ  = 11'b10110100000;
   localparam logic [10:0] OP_CBNZ = 11'b10110101000;
   localparam logic [10:0] OP_B    = 11'b00010100000;
   localparam logic [10:0] OP_HALT = 11'b11111111111;

   localparam logic [10:0] MSK_FULL = 11'b11111111111;
   localparam logic [10:0] MSK_ADDI = 11'b11111111110;
   localparam logic [10:0] MSK_CB   = 11'b11111111000;
   localparam logic [10:0] MSK_B    = 11'b11111100000;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;

   localparam logic [1:0] ALUS_REG  = 2'b00;
   localparam logic [1:0] ALUS_DIMM = 2'b01;
   localparam logic [1:0] ALUS_IIMM = 2'b10;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_CB  = 2'b01;
   localparam logic [1:0] ALUOP_FN  = 2'b10;

   typedef struct packed {
      logic       reg2loc;
      logic [1:0] alu_src;
      logic [1:0] alu_op;
   } alu_ctl_t;

   function automatic logic op_match(
      logic [10:0] op, logic [10:0] pat, logic [10:0] msk);
      return ((op ^ pat) & msk) == 11'b0;
   endfunction

   function automatic alu_ctl_t alu_ctl(cls_e c);
      alu_ctl_t a;
      a = '0;
      case (c)
         C_R:    a = '{1'b0, ALUS_REG,  ALUOP_FN};
         C_ADDI: a = '{1'b0, ALUS_IIMM, ALUOP_FN};
         C_LDUR: a = '{1'b0, ALUS_DIMM, ALUOP_ADD};
         C_STUR: a = '{1'b1, ALUS_DIMM, ALUOP_ADD};
         C_CBZ,
         C_CBNZ: a = '{1'b1, ALUS_REG,  ALUOP_CB};
         default: a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/cpu_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// master = sequencer side, slave = datapath side.
interface cpu_multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [10:0]      inst31_21;
   logic             zero;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             reg2loc;
   logic [1:0]       alu_src;
   logic [1:0]       alu_op;
   logic             dmem_read;
   logic             dmem_write;
   logic             mem_to_reg;
   logic             reg_write;
   logic             halted;
   logic             illegal;
   logic [CNT_W-1:0] inst_count;

   modport master (
      input  inst31_21, zero, imem_ready, dmem_ready,
      output imem_req, ir_write, pc_write, pc_src,
      output reg2loc, alu_src, alu_op,
      output dmem_read, dmem_write, mem_to_reg, reg_write,
      output halted, illegal, inst_count
   );

   modport slave (
      output inst31_21, zero, imem_ready, dmem_ready,
      input  imem_req, ir_write, pc_write, pc_src,
      input  reg2loc, alu_src, alu_op,
      input  dmem_read, dmem_write, mem_to_reg, reg_write,
      input  halted, illegal, inst_count
   );
endinterface

// File: rtl/cpu_inst_decode.sv
// Combinational opcode classifier for inst[31:21].
module cpu_inst_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [10:0] op_i,
   output cls_e        cls_o,
   output logic        ill_o
);

   always_comb begin
      cls_o = C_ILL;
      unique case (1'b1)
         op_match(op_i, OP_LDUR, MSK_FULL): cls_o = C_LDUR;
         op_match(op_i, OP_STUR, MSK_FULL): cls_o = C_STUR;
         op_match(op_i, OP_ADD,  MSK_FULL): cls_o = C_R;
         op_match(op_i, OP_SUB,  MSK_FULL): cls_o = C_R;
         op_match(op_i, OP_AND,  MSK_FULL): cls_o = C_R;
         op_match(op_i, OP_ORR,  MSK_FULL): cls_o = C_R;
         op_match(op_i, OP_ADDI, MSK_ADDI): cls_o = C_ADDI;
         op_match(op_i, OP_CBZ,  MSK_CB):   cls_o = C_CBZ;
         op_match(op_i, OP_CBNZ, MSK_CB):   cls_o = C_CBNZ;
         op_match(op_i, OP_B,    MSK_B):    cls_o = C_B;
         op_match(op_i, OP_HALT, MSK_FULL): cls_o = C_HALT;
         default:                           cls_o = C_ILL;
      endcase
   end

   assign ill_o = (cls_o == C_ILL);

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// LEGv8 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with
// req/ready memory waits, timeout, sticky HALTED/ERROR.
module cpu_multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 255
) (
   input logic                  clk,
   input logic                  reset,
   cpu_multicycle_ctrl_if.master bus
);

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d;
   logic [TO_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   cls_e             dec_cls;
   logic             dec_ill;
   logic             retire;
   logic             timeout;

   cpu_inst_decode u_dec (
      .op_i  (bus.inst31_21),
      .cls_o (dec_cls),
      .ill_o (dec_ill)
   );

   assign timeout = (wait_q == TO_W'(MEM_TIMEOUT));

   always_comb begin
      state_d         = state_q;
      cls_d           = cls_q;
      wait_d          = wait_q;
      cnt_d           = cnt_q;
      retire          = 1'b0;
      bus.imem_req    = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.pc_src      = PC_SEQ;
      bus.reg2loc     = 1'b0;
      bus.alu_src     = ALUS_REG;
      bus.alu_op      = ALUOP_ADD;
      bus.dmem_read   = 1'b0;
      bus.dmem_write  = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.reg_write   = 1'b0;
      bus.halted      = 1'b0;
      bus.illegal     = 1'b0;
      bus.inst_count  = '0;
      // Reset forces every output low regardless of the held state.
      if (!reset) begin
         bus.inst_count = cnt_q;
         case (state_q)
            S_FETCH: begin
               bus.imem_req = 1'b1;
               if (bus.imem_ready) begin
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = S_DECODE;
               end else if (timeout) begin
                  state_d = S_ERROR;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            S_DECODE: begin
               cls_d = dec_cls;
               unique case (1'b1)
                  dec_cls == C_HALT: state_d = S_HALTED;
                  dec_ill:           state_d = S_ERROR;
                  dec_cls == C_B: begin
                     bus.pc_write = 1'b1;
                     bus.pc_src   = PC_BR;
                     retire       = 1'b1;
                  end
                  default:           state_d = S_EXEC;
               endcase
            end
            S_EXEC: begin
               {bus.reg2loc, bus.alu_src, bus.alu_op} = alu_ctl(cls_q);
               unique case (1'b1)
                  cls_q == C_CBZ || cls_q == C_CBNZ: begin
                     if (bus.zero == (cls_q == C_CBZ)) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = PC_BR;
                     end
                     retire = 1'b1;
                  end
                  cls_q == C_LDUR || cls_q == C_STUR: begin
                     state_d = S_MEM;
                     wait_d  = '0;
                  end
                  default: state_d = S_WB;
               endcase
            end
            S_MEM: begin
               {bus.reg2loc, bus.alu_src, bus.alu_op} = alu_ctl(cls_q);
               bus.dmem_read  = (cls_q == C_LDUR);
               bus.dmem_write = (cls_q == C_STUR);
               if (bus.dmem_ready) begin
                  if (cls_q == C_LDUR) state_d = S_WB;
                  else                 retire  = 1'b1;
               end else if (timeout) begin
                  state_d = S_ERROR;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            S_WB: begin
               {bus.reg2loc, bus.alu_src, bus.alu_op} = alu_ctl(cls_q);
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = (cls_q == C_LDUR);
               retire         = 1'b1;
            end
            S_HALTED: bus.halted  = 1'b1;
            S_ERROR:  bus.illegal = 1'b1;
            default:  state_d     = S_ERROR;
         endcase
         if (retire) begin
            state_d = S_FETCH;
            wait_d  = '0;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cls_q   <= C_ILL;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Self-checking bench: per-cycle expected control vectors from an
// instruction-level model are queued and checked by a monitor.
module tb_cpu_multicycle_ctrl;

   localparam int T = 255;

   typedef enum {K_R, K_ADDI, K_LDUR, K_STUR, K_CBZ, K_CBNZ,
                 K_B, K_HALT, K_ILL} kind_e;

   typedef struct packed {
      logic        imem_req;
      logic        ir_write;
      logic        pc_write;
      logic [1:0]  pc_src;
      logic        reg2loc;
      logic [1:0]  alu_src;
      logic [1:0]  alu_op;
      logic        dmem_read;
      logic        dmem_write;
      logic        mem_to_reg;
      logic        reg_write;
      logic        halted;
      logic        illegal;
      logic [31:0] cnt;
   } vec_t;

   typedef struct {
      vec_t  v;
      bit    care;
      string nm;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] count = 0;
   exp_t q[$];

   cpu_multicycle_ctrl_if #(.CNT_W(32)) bus ();

   cpu_multicycle_ctrl #(
      .CNT_W(32), .TO_W(8), .MEM_TIMEOUT(T)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic kind_e ref_kind(logic [10:0] op);
      if (op == 11'b11111000010) return K_LDUR;
      if (op == 11'b11111000000) return K_STUR;
      if (op == 11'b10001011000 || op == 11'b11001011000 ||
          op == 11'b10001010000 || op == 11'b10101010000)
         return K_R;
      if (op[10:1] == 10'b1001000100) return K_ADDI;
      if (op[10:3] == 8'b10110100) return K_CBZ;
      if (op[10:3] == 8'b10110101) return K_CBNZ;
      if (op[10:5] == 6'b000101) return K_B;
      if (op == 11'b11111111111) return K_HALT;
      return K_ILL;
   endfunction

   function automatic vec_t base();
      vec_t v;
      v = '0;
      v.cnt = count;
      return v;
   endfunction

   function automatic vec_t with_alu(vec_t vi, kind_e k);
      vec_t v;
      v = vi;
      case (k)
         K_R:    begin v.alu_src = 2'd0; v.alu_op = 2'd2; end
         K_ADDI: begin v.alu_src = 2'd2; v.alu_op = 2'd2; end
         K_LDUR: begin v.alu_src = 2'd1; v.alu_op = 2'd0; end
         K_STUR: begin v.alu_src = 2'd1; v.alu_op = 2'd0; v.reg2loc = 1'b1; end
         K_CBZ, K_CBNZ: begin v.alu_op = 2'd1; v.reg2loc = 1'b1; end
         default: ;
      endcase
      return v;
   endfunction

   task automatic step(input logic [10:0] op, input bit ir, input bit dr,
                       input bit z, input bit rst, input vec_t v,
                       input bit care, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      bus.inst31_21  = op;
      bus.imem_ready = ir;
      bus.dmem_ready = dr;
      bus.zero       = z;
      reset          = rst;
      e.v = v;
      e.care = care;
      e.nm = nm;
      q.push_back(e);
   endtask

   task automatic do_reset();
      count = 0;
      step(11'd0, 1'b1, 1'b1, 1'b0, 1'b1, base(), 1'b1, "reset");
   endtask

   task automatic dead(input bit h, input logic [10:0] op);
      vec_t v;
      for (int i = 0; i < 4; i++) begin
         v = base();
         v.halted = h;
         v.illegal = !h;
         step(op, 1'b1, 1'b1, 1'b0, 1'b0, v, 1'b1, h ? "halted" : "error");
      end
      do_reset();
   endtask

   task automatic run_inst(input logic [10:0] op, input int wf,
                           input int wm, input bit z, input int abort_m);
      kind_e k;
      vec_t v;
      bit rdy;
      k = ref_kind(op);
      for (int i = 0; ; i++) begin
         rdy = (i == wf);
         v = base();
         v.imem_req = 1'b1;
         v.ir_write = rdy;
         v.pc_write = rdy;
         step(op, rdy, 1'b0, z, 1'b0, v, 1'b1, "fetch");
         if (rdy) break;
         if (i == T) begin
            dead(1'b0, op);
            return;
         end
      end
      v = base();
      if (k == K_B) begin
         v.pc_write = 1'b1;
         v.pc_src = 2'b01;
      end
      step(op, 1'b0, 1'b0, z, 1'b0, v, 1'b1, "decode");
      if (k == K_HALT) begin dead(1'b1, op); return; end
      if (k == K_ILL) begin dead(1'b0, op); return; end
      if (k == K_B) begin count++; return; end
      v = with_alu(base(), k);
      if ((k == K_CBZ && z) || (k == K_CBNZ && !z)) begin
         v.pc_write = 1'b1;
         v.pc_src = 2'b01;
      end
      step(op, 1'b0, 1'b0, z, 1'b0, v, 1'b1, "exec");
      if (k == K_CBZ || k == K_CBNZ) begin count++; return; end
      if (k == K_LDUR || k == K_STUR) begin
         for (int i = 0; ; i++) begin
            rdy = (i == wm);
            v = with_alu(base(), k);
            v.dmem_read = (k == K_LDUR);
            v.dmem_write = (k == K_STUR);
            step(op, 1'b0, rdy, z, 1'b0, v, 1'b1, "mem");
            if (abort_m != 0 && i + 1 == abort_m) begin
               do_reset();
               return;
            end
            if (rdy) break;
            if (i == T) begin
               dead(1'b0, op);
               return;
            end
         end
         if (k == K_STUR) begin count++; return; end
      end
      v = base();
      v.reg_write = 1'b1;
      v.mem_to_reg = (k == K_LDUR);
      step(op, 1'b0, 1'b0, z, 1'b0, v, 1'b0, "wb");
      count++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      vec_t a;
      vec_t x;
      if (q.size() != 0) begin
         e = q.pop_front();
         a.imem_req   = bus.imem_req;
         a.ir_write   = bus.ir_write;
         a.pc_write   = bus.pc_write;
         a.pc_src     = bus.pc_src;
         a.reg2loc    = bus.reg2loc;
         a.alu_src    = bus.alu_src;
         a.alu_op     = bus.alu_op;
         a.dmem_read  = bus.dmem_read;
         a.dmem_write = bus.dmem_write;
         a.mem_to_reg = bus.mem_to_reg;
         a.reg_write  = bus.reg_write;
         a.halted     = bus.halted;
         a.illegal    = bus.illegal;
         a.cnt        = bus.inst_count;
         x = e.v;
         if (!e.care) begin
            a.reg2loc = 1'b0; a.alu_src = 2'd0; a.alu_op = 2'd0;
            x.reg2loc = 1'b0; x.alu_src = 2'd0; x.alu_op = 2'd0;
         end
         checks++;
         if (a !== x) begin
            errors++;
            $display("FAIL %s got %h exp %h", e.nm, a, x);
         end
      end
   end

   function automatic logic [10:0] rand_op();
      logic [10:0] r;
      r = 11'($urandom);
      case ($urandom_range(0, 13))
         0:  return 11'b11111000010;
         1:  return 11'b11111000000;
         2:  return 11'b10001011000;
         3:  return 11'b11001011000;
         4:  return 11'b10001010000;
         5:  return 11'b10101010000;
         6:  return {10'b1001000100, r[0]};
         7:  return {8'b10110100, r[2:0]};
         8:  return {8'b10110101, r[2:0]};
         9:  return {6'b000101, r[4:0]};
         10: return ($urandom_range(0, 3) == 0) ? 11'h7FF : 11'b11111000010;
         default: return r;
      endcase
   endfunction

   initial begin
      bus.inst31_21  = '0;
      bus.zero       = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      do_reset();
      run_inst(11'b10001011000, 0, 0, 1'b0, 0);
      run_inst(11'b11111000010, 0, 3, 1'b0, 0);
      run_inst(11'b10110100000, 0, 0, 1'b1, 0);
      run_inst(11'b10110101000, 0, 0, 1'b1, 0);
      run_inst(11'b10010001001, 1, 0, 1'b0, 0);
      run_inst(11'b00010111111, 0, 0, 1'b0, 0);
      run_inst(11'b11111000000, 0, 20, 1'b0, 2);
      run_inst(11'b10001011000, 0, 0, 1'b0, 0);
      run_inst(11'b10001011000, T + 1, 0, 1'b0, 0);
      run_inst(11'b10101010000, T, 0, 1'b0, 0);
      run_inst(11'b11111000000, 0, T, 1'b0, 0);
      run_inst(11'b11111000010, 0, T + 1, 1'b0, 0);
      run_inst(11'b00000000000, 0, 0, 1'b0, 0);
      run_inst(11'b11001011000, 0, 0, 1'b0, 0);
      run_inst(11'b11111111111, 0, 0, 1'b0, 0);
      for (int n = 0; n < 300; n++)
         run_inst(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d exp 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
